// File: rtl/mul_pipe_unit_pkg.sv
// Shared CPU constants: multiplier opcode encoding and the default datapath width.
package cpu_consts;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    MULW   = 3'b100
  } mul_op_e;

  // Folds undefined encodings (and MULW on a 32-bit core) onto MUL.
  function automatic mul_op_e norm_op(input logic [2:0] raw, input logic has_w);
    case (raw)
      3'b001:  return MULH;
      3'b010:  return MULHSU;
      3'b011:  return MULHU;
      3'b100:  return has_w ? MULW : MUL;
      default: return MUL;
    endcase
  endfunction

endpackage

// File: rtl/mul_part_prod.sv
// One registered unsigned W x W partial product; holds while stalled unless killed.
module mul_part_prod #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           kill,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod <= '0;
    end else if (kill || !stall) begin
      prod <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined RV32M/RV64M multiplier: sign select, four half-width partial products,
// assemble and negate, then optional output register slices.
module mul_pipe_unit
  import cpu_consts::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            stall_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] res_o,
  output logic            valid_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en_o,
  output logic            busy_o
);

  localparam int H  = XLEN / 2;
  localparam int NS = LATENCY - 3;

  mul_op_e         op_n;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            a_neg, b_neg;

  assign op_n = norm_op(op_i, XLEN == 64);

  generate
    if (XLEN == 64) begin : g_w
      assign a_ext = (op_n == MULW) ? {{32{opr_a_i[31]}}, opr_a_i[31:0]} : opr_a_i;
      assign b_ext = (op_n == MULW) ? {{32{opr_b_i[31]}}, opr_b_i[31:0]} : opr_b_i;
    end else begin : g_nw
      assign a_ext = opr_a_i;
      assign b_ext = opr_b_i;
    end
  endgenerate

  assign a_neg = (op_n == MULH || op_n == MULHSU || op_n == MULW) && a_ext[XLEN-1];
  assign b_neg = (op_n == MULH || op_n == MULW) && b_ext[XLEN-1];
  // Magnitude of the most negative value is 2^(XLEN-1), which still fits unsigned.
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  logic            s1_valid, s1_neg;
  logic [XLEN-1:0] s1_a, s1_b;
  mul_op_e         s1_op;
  logic [4:0]      s1_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= MUL;
      s1_rd    <= '0;
    end else begin
      if (kill_i)        s1_valid <= 1'b0;
      else if (!stall_i) s1_valid <= valid_i;
      if (!stall_i) begin
        s1_neg <= a_neg ^ b_neg;
        s1_a   <= a_mag;
        s1_b   <= b_mag;
        s1_op  <= op_n;
        s1_rd  <= rd_addr_i;
      end
    end
  end

  logic [H-1:0]    a_h [2];
  logic [H-1:0]    b_h [2];
  logic [XLEN-1:0] pp  [4];

  assign a_h[0] = s1_a[H-1:0];
  assign a_h[1] = s1_a[XLEN-1:H];
  assign b_h[0] = s1_b[H-1:0];
  assign b_h[1] = s1_b[XLEN-1:H];

  // pp[0]=lo*lo, pp[1]=lo(a)*hi(b), pp[2]=hi(a)*lo(b), pp[3]=hi*hi
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      mul_part_prod #(.W(H)) u_pp (
        .clk   (clk),
        .reset (reset),
        .stall (stall_i),
        .kill  (kill_i),
        .a     (a_h[gi/2]),
        .b     (b_h[gi%2]),
        .prod  (pp[gi])
      );
    end
  endgenerate

  logic       s2_valid, s2_neg;
  mul_op_e    s2_op;
  logic [4:0] s2_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_op    <= MUL;
      s2_rd    <= '0;
    end else begin
      if (kill_i)        s2_valid <= 1'b0;
      else if (!stall_i) s2_valid <= s1_valid;
      if (!stall_i) begin
        s2_neg <= s1_neg;
        s2_op  <= s1_op;
        s2_rd  <= s1_rd;
      end
    end
  end

  logic [2*XLEN-1:0] mag_prod, prod;
  logic [XLEN-1:0]   w_res, res_next;

  always_comb begin
    mag_prod = {pp[3], pp[0]}
             + {{H{1'b0}}, pp[1], {H{1'b0}}}
             + {{H{1'b0}}, pp[2], {H{1'b0}}};
    prod     = s2_neg ? -mag_prod : mag_prod;
  end

  generate
    if (XLEN == 64) begin : g_wres
      assign w_res = {{32{prod[31]}}, prod[31:0]};
    end else begin : g_nwres
      assign w_res = prod[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    res_next = prod[XLEN-1:0];
    case (s2_op)
      MULH, MULHSU, MULHU: res_next = prod[2*XLEN-1:XLEN];
      MULW:                res_next = w_res;
      default:             ;
    endcase
  end

  // Index 0 is the stage-3 register; higher indices are the extra latency slices.
  logic [NS:0]     st_valid;
  logic [XLEN-1:0] st_res [NS+1];
  logic [4:0]      st_rd  [NS+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid <= '0;
      for (int i = 0; i <= NS; i++) begin
        st_res[i] <= '0;
        st_rd[i]  <= '0;
      end
    end else begin
      if (kill_i) begin
        st_valid <= '0;
      end else if (!stall_i) begin
        st_valid[0] <= s2_valid;
        for (int i = 1; i <= NS; i++) st_valid[i] <= st_valid[i-1];
      end
      if (!stall_i) begin
        st_res[0] <= res_next;
        st_rd[0]  <= s2_rd;
        for (int i = 1; i <= NS; i++) begin
          st_res[i] <= st_res[i-1];
          st_rd[i]  <= st_rd[i-1];
        end
      end
    end
  end

  assign valid_o    = st_valid[NS];
  assign res_o      = st_res[NS];
  assign rd_addr_o  = st_rd[NS];
  assign rd_wr_en_o = valid_o && (rd_addr_o != 5'd0);
  assign busy_o     = s1_valid || s2_valid || (|st_valid);

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Drives four multiplier configurations with shared stimulus and checks each against
// an arithmetic reference model with an in-flight op list.
module tb_mul_pipe_unit;
  import cpu_consts::*;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          age;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0, stall_in = 1'b0, kill_in = 1'b0;
  logic [2:0]  op_in = 3'd0;
  logic [63:0] a_in = '0, b_in = '0;
  logic [4:0]  rd_in = '0;

  logic [63:0] res_w [4];
  logic [4:0]  rd_w  [4];
  logic [3:0]  valid_w, wr_w, busy_w;

  int total = 0;
  int bad   = 0;
  int seen0 = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the operands as mathematical integers.
  function automatic logic [63:0] ref_mul(input int xl, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    logic [63:0] am, bm, mask;
    logic [2:0]  o;
    o = op;
    if (o > 3'd4 || (o == 3'd4 && xl == 32)) o = 3'd0;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am = a & mask;
    bm = b & mask;
    if (o == 3'd4) begin
      ea = 130'($signed(a[31:0]));
      eb = 130'($signed(b[31:0]));
      p  = ea * eb;
      return {{32{p[31]}}, p[31:0]};
    end
    ea = 130'(am);
    eb = 130'(bm);
    if ((o == 3'd1 || o == 3'd2) && am[xl-1]) ea = ea - (130'sd1 <<< xl);
    if (o == 3'd1 && bm[xl-1])                eb = eb - (130'sd1 <<< xl);
    p = ea * eb;
    if (o == 3'd0) return 64'(p) & mask;
    return 64'(p >>> xl) & mask;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int XL = (gi == 3) ? 32 : 64;
    localparam int LT = (gi == 0) ? 4 : (gi == 1) ? 3 : 6;
    logic [XL-1:0] r;
    ent_t q[$];

    mul_pipe_unit #(.XLEN(XL), .LATENCY(LT)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_in),
      .op_i       (op_in),
      .opr_a_i    (a_in[XL-1:0]),
      .opr_b_i    (b_in[XL-1:0]),
      .rd_addr_i  (rd_in),
      .stall_i    (stall_in),
      .kill_i     (kill_in),
      .res_o      (r),
      .valid_o    (valid_w[gi]),
      .rd_addr_o  (rd_w[gi]),
      .rd_wr_en_o (wr_w[gi]),
      .busy_o     (busy_w[gi])
    );
    assign res_w[gi] = 64'(r);

    initial forever begin
      @(posedge clk or posedge reset);
      if (reset || kill_in) begin
        q.delete();
      end else if (!stall_in) begin
        foreach (q[k]) q[k].age++;
        while (q.size() > 0 && q[0].age > LT) void'(q.pop_front());
        if (valid_in) q.push_back('{ref_mul(XL, op_in, a_in, b_in), rd_in, 1});
      end
    end

    initial forever begin
      logic ev;
      @(negedge clk);
      if (!reset) begin
        ev = (q.size() > 0) && (q[0].age == LT);
        check_val($sformatf("valid%0d", gi), 64'(valid_w[gi]), 64'(ev));
        check_val($sformatf("busy%0d", gi), 64'(busy_w[gi]), 64'(q.size() > 0));
        check_val($sformatf("wren%0d", gi), 64'(wr_w[gi]), 64'(ev && q[0].rd != 5'd0));
        if (ev) begin
          check_val($sformatf("res%0d", gi), res_w[gi], q[0].res);
          check_val($sformatf("rd%0d", gi), 64'(rd_w[gi]), 64'(q[0].rd));
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [2:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd, input logic st, input logic kl);
    valid_in = v; op_in = op; a_in = a; b_in = b; rd_in = rd; stall_in = st; kill_in = kl;
    @(negedge clk);
    if (valid_w[0] && !stall_in) seen0++;
    @(posedge clk);
    #1;
  endtask

  // Single op into the LATENCY=4 instance, result checked against a fixed constant.
  task automatic directed(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
    cyc(1'b1, op, a, b, rd, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_val({tag, "_v"}, 64'(valid_w[0]), 64'd1);
    check_val({tag, "_r"}, res_w[0], exp);
    check_val({tag, "_we"}, 64'(wr_w[0]), 64'(rd != 5'd0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h1;
      4:       return 64'hFFFF_FFFF_8000_0000;
      5:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val("rst_valid", 64'(valid_w[i]), 64'd0);
      check_val("rst_res", res_w[i], 64'd0);
      check_val("rst_rd", 64'(rd_w[i]), 64'd0);
      check_val("rst_busy", 64'(busy_w[i]), 64'd0);
    end
    reset = 1'b0;
    cyc(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);

    directed("mulhu_max", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    directed("mul_max", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'h1);
    directed("mulh_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7, 64'h4000_0000_0000_0000);
    directed("mulhsu", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    directed("mulw_rd0", 3'd4, 64'h1_0000_0002, 64'h7FFF_FFFF, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    directed("neg_zero", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd3, 64'h0);
    directed("undef_op", 3'd7, 64'h3, 64'h5, 5'd2, 64'hF);

    // Four ops with a three-cycle stall mid-stream; consumer must see exactly four.
    seen0 = 0;
    cyc(1'b1, 3'd0, 64'd11, 64'd3, 5'd1, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 64'hFFFF_0000_0000_0000, 64'h10, 5'd2, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 3'd1, 64'd99, 64'd99, 5'd9, 1'b1, 1'b0);
    cyc(1'b1, 3'd4, 64'h7FFF_FFFF, 64'h2, 5'd3, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 64'h8000_0000_0000_0000, 64'h3, 5'd4, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    check_val("stall_count", 64'(seen0), 64'd4);

    // Fill with three ops, then kill together with valid and stall.
    repeat (3) cyc(1'b1, 3'd0, 64'd6, 64'd7, 5'd8, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 64'd1, 64'd1, 5'd8, 1'b1, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_val("kill_busy", 64'(busy_w[i]), 64'd0);
    @(posedge clk);
    #1;
    seen0 = 0;
    repeat (10) cyc(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    check_val("kill_none", 64'(seen0), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      cyc($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
          5'($urandom_range(0, 31)), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3);
    end
    repeat (8) cyc(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
